// File: rtl/fpnew_rob_retire.sv
// In-order completion buffer: ops get a slot at issue, lanes write results back
// out of order, and results retire strictly in issue order through one port.
module fpnew_rob_retire #(
  parameter int unsigned Width    = 16,
  parameter int unsigned NumLanes = 4,
  parameter int unsigned Depth    = 8,
  parameter type         TagType  = logic,
  localparam int unsigned SlotW   = $clog2(Depth),
  localparam int unsigned LaneW   = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [LaneW-1:0]                   in_lane_i,
  input  TagType                             in_tag_i,
  output logic [NumLanes-1:0]                lane_valid_o,
  input  logic [NumLanes-1:0]                lane_ready_i,
  output logic [SlotW-1:0]                   lane_slot_o,
  input  logic [NumLanes-1:0]                res_valid_i,
  output logic [NumLanes-1:0]                res_ready_o,
  input  logic [NumLanes-1:0][SlotW-1:0]     res_slot_i,
  input  logic [NumLanes-1:0][Width-1:0]     res_data_i,
  input  logic [NumLanes-1:0][4:0]           res_status_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [Width-1:0]                   out_data_o,
  output logic [4:0]                         out_status_o,
  output TagType                             out_tag_o,
  output logic                               busy_o,
  output logic [SlotW:0]                     count_o,
  output logic                               err_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready of the same interface.

  logic [SlotW:0]      head_q, tail_q, count_q;
  logic [Depth-1:0]    alloc_q, done_q;
  logic                err_q;
  TagType              tag_q    [Depth];
  logic [Width-1:0]    data_q   [Depth];
  logic [4:0]          status_q [Depth];

  logic [SlotW-1:0]    head_idx, tail_idx;
  logic                full, empty, clear, issue, retire;
  logic [NumLanes-1:0] dup, cap_ok;
  logic                cap_err;

  assign head_idx = head_q[SlotW-1:0];
  assign tail_idx = tail_q[SlotW-1:0];
  assign full     = (head_q ^ tail_q) == {1'b1, {SlotW{1'b0}}};
  assign empty    = head_q == tail_q;
  assign clear    = rst_i | flush_i;

  assign in_ready_o  = ~full & lane_ready_i[in_lane_i];
  assign lane_slot_o = tail_idx;
  assign issue       = in_valid_i & in_ready_o;

  always_comb begin
    lane_valid_o = '0;
    if (in_valid_i && !full) lane_valid_o[in_lane_i] = 1'b1;
  end

  assign res_ready_o = {NumLanes{~clear}};

  // A lane loses if any lower lane presents a result for the same slot.
  always_comb begin
    dup = '0;
    for (int l = 1; l < NumLanes; l++) begin
      for (int j = 0; j < l; j++) begin
        if (res_valid_i[j] && (res_slot_i[j] == res_slot_i[l])) dup[l] = 1'b1;
      end
    end
  end

  always_comb begin
    cap_ok  = '0;
    cap_err = 1'b0;
    for (int l = 0; l < NumLanes; l++) begin
      if (res_valid_i[l] && !clear) begin
        if (!dup[l] && alloc_q[res_slot_i[l]] && !done_q[res_slot_i[l]]) cap_ok[l] = 1'b1;
        else cap_err = 1'b1;
      end
    end
  end

  assign out_valid_o  = ~empty & done_q[head_idx];
  assign retire       = out_valid_o & out_ready_i;
  assign out_data_o   = out_valid_o ? data_q[head_idx]   : '0;
  assign out_status_o = out_valid_o ? status_q[head_idx] : '0;
  assign out_tag_o    = out_valid_o ? tag_q[head_idx]    : '0;

  assign count_o = count_q;
  assign busy_o  = count_q != '0;
  assign err_o   = err_q;

  // Control state. Captures only hit allocated, not-done slots, so they never
  // collide with the head being retired or the tail being allocated.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      if (rst_i) err_q <= 1'b0;
    end else begin
      for (int l = 0; l < NumLanes; l++) begin
        if (cap_ok[l]) done_q[res_slot_i[l]] <= 1'b1;
      end
      if (cap_err) err_q <= 1'b1;
      if (retire) begin
        alloc_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head_q            <= head_q + (SlotW+1)'(1);
      end
      if (issue) begin
        alloc_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail_q            <= tail_q + (SlotW+1)'(1);
      end
      if (issue && !retire)      count_q <= count_q + (SlotW+1)'(1);
      else if (!issue && retire) count_q <= count_q - (SlotW+1)'(1);
    end
  end

  // Payload storage needs no reset: it is only visible while done is set.
  always_ff @(posedge clk_i) begin
    if (!clear) begin
      for (int l = 0; l < NumLanes; l++) begin
        if (cap_ok[l]) begin
          data_q[res_slot_i[l]]   <= res_data_i[l];
          status_q[res_slot_i[l]] <= res_status_i[l];
        end
      end
      if (issue) tag_q[tail_idx] <= in_tag_i;
    end
  end

endmodule

// File: tb/tb_fpnew_rob_retire.sv
// Randomized bench for fpnew_rob_retire, checked every cycle against an
// issue-order queue model of the in-flight ops.
module tb_fpnew_rob_retire;
  localparam int W = 16;
  localparam int NL = 4;
  localparam int D = 8;

  logic                  clk = 1'b0;
  logic                  rst, flush, in_valid, in_ready, in_tag, out_valid, out_ready;
  logic                  out_tag, busy, err;
  logic [1:0]            in_lane;
  logic [NL-1:0]         lane_valid, lane_ready, res_valid, res_ready;
  logic [2:0]            lane_slot;
  logic [NL-1:0][2:0]    res_slot;
  logic [NL-1:0][W-1:0]  res_data;
  logic [NL-1:0][4:0]    res_status;
  logic [W-1:0]          out_data;
  logic [4:0]            out_status;
  logic [3:0]            count;

  fpnew_rob_retire #(.Width(W), .NumLanes(NL), .Depth(D), .TagType(logic)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_lane_i(in_lane), .in_tag_i(in_tag),
    .lane_valid_o(lane_valid), .lane_ready_i(lane_ready), .lane_slot_o(lane_slot),
    .res_valid_i(res_valid), .res_ready_o(res_ready), .res_slot_i(res_slot),
    .res_data_i(res_data), .res_status_i(res_status),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_status_o(out_status), .out_tag_o(out_tag),
    .busy_o(busy), .count_o(count), .err_o(err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard: in-flight ops in issue order, head first.
  typedef struct {
    logic         tag;
    logic         done;
    logic [W-1:0] data;
    logic [4:0]   status;
  } ent_t;
  ent_t exp_q[$];
  int   head_ord;
  logic err_m;
  int   n_cmp, n_err, cyc;
  int   p_in, p_res, p_out, p_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver: one cycle of random stimulus, checks, then model update.
  task automatic step();
    int   inflight[$];
    int   sz, idx, hs;
    logic full_m, ov_m;
    logic [NL-1:0] ok;
    ent_t e;
    @(negedge clk);
    cyc++;
    rst        = ($urandom_range(0, 299) == 0);
    flush      = !rst && ($urandom_range(0, 99) < 2);
    in_valid   = ($urandom_range(0, 99) < p_in);
    in_lane    = 2'($urandom_range(0, NL-1));
    in_tag     = 1'($urandom);
    out_ready  = ($urandom_range(0, 99) < p_out);
    for (int l = 0; l < NL; l++) lane_ready[l] = ($urandom_range(0, 99) < 80);
    for (int i = 0; i < exp_q.size(); i++)
      if (!exp_q[i].done) inflight.push_back((head_ord + i) % D);
    for (int l = 0; l < NL; l++) begin
      res_valid[l]  = ($urandom_range(0, 99) < p_res);
      res_data[l]   = W'($urandom);
      res_status[l] = 5'($urandom);
      if (inflight.size() > 0 && $urandom_range(0, 99) >= p_bad)
        res_slot[l] = 3'(inflight[$urandom_range(0, inflight.size()-1)]);
      else
        res_slot[l] = 3'($urandom_range(0, D-1));
    end
    #1;
    sz     = exp_q.size();
    full_m = (sz == D);
    ov_m   = (sz > 0) && exp_q[0].done;
    check("count", 32'(count), 32'(sz));
    check("busy", 32'(busy), 32'(sz != 0));
    check("err", 32'(err), 32'(err_m));
    check("in_ready", 32'(in_ready), 32'(!full_m && lane_ready[in_lane]));
    check("lane_valid", 32'(lane_valid), (in_valid && !full_m) ? (32'd1 << in_lane) : 32'd0);
    check("lane_slot", 32'(lane_slot), 32'((head_ord + sz) % D));
    check("res_ready", 32'(res_ready), (rst || flush) ? 32'd0 : 32'hF);
    check("out_valid", 32'(out_valid), 32'(ov_m));
    check("out_data", 32'(out_data), ov_m ? 32'(exp_q[0].data) : 32'd0);
    check("out_status", 32'(out_status), ov_m ? 32'(exp_q[0].status) : 32'd0);
    check("out_tag", 32'(out_tag), ov_m ? 32'(exp_q[0].tag) : 32'd0);
    if (rst) begin
      exp_q.delete(); head_ord = 0; err_m = 1'b0;
    end else if (flush) begin
      exp_q.delete(); head_ord = 0;
    end else begin
      ok = '0;
      for (int l = 0; l < NL; l++) begin
        if (res_valid[l]) begin
          hs = 0;
          for (int j = 0; j < l; j++) if (res_valid[j] && res_slot[j] == res_slot[l]) hs = 1;
          idx = (int'(res_slot[l]) - head_ord + D) % D;
          if (hs == 0 && idx < sz && !exp_q[idx].done) ok[l] = 1'b1;
          else err_m = 1'b1;
        end
      end
      for (int l = 0; l < NL; l++) begin
        if (ok[l]) begin
          idx = (int'(res_slot[l]) - head_ord + D) % D;
          e = exp_q[idx];
          e.done = 1'b1; e.data = res_data[l]; e.status = res_status[l];
          exp_q[idx] = e;
        end
      end
      if (ov_m && out_ready) begin
        void'(exp_q.pop_front());
        head_ord = (head_ord + 1) % D;
      end
      if (in_valid && !full_m && lane_ready[in_lane]) begin
        e.tag = in_tag; e.done = 1'b0; e.data = '0; e.status = '0;
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; head_ord = 0; err_m = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_lane = '0; in_tag = 1'b1;
    lane_ready = '1; res_valid = '0; res_slot = '0; res_data = '0; res_status = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_res_ready", 32'(res_ready), 32'd0);
    // Phases vary the traffic mix: fill-to-full, drain, error injection, balanced.
    for (int ph = 0; ph < 10; ph++) begin
      case (ph % 5)
        0: begin p_in = 90; p_res = 5;  p_out = 10; p_bad = 0;  end
        1: begin p_in = 20; p_res = 60; p_out = 90; p_bad = 0;  end
        2: begin p_in = 60; p_res = 40; p_out = 60; p_bad = 30; end
        3: begin p_in = 95; p_res = 25; p_out = 0;  p_bad = 5;  end
        default: begin p_in = 70; p_res = 35; p_out = 70; p_bad = 10; end
      endcase
      for (int c = 0; c < 400; c++) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
